// File: rtl/score_display.sv
// -----------------------------------------------------------------------------
// score_display
//   Real-time score keeper and glyph renderer for the StickmanRun VGA overlay.
//   A frame-tick divider advances a NUM_DIGITS-digit BCD score that saturates
//   at all nines; a session high score is committed on game_over. The render
//   path maps (DrawX, DrawY) onto one of NUM_DIGITS scaled 8x16 glyph boxes,
//   does a single digits_rom lookup and registers the foreground bit.
//
//   Optional build macro: SCORE_LEAD_ZERO_BLANK_EN
//     defined   -> leading zero digits are blanked (LS digit always drawn)
//     undefined -> every digit is drawn, including leading zeros
//
// Ports
//   Clk, Reset_n   clock, asynchronous active-low reset
//   frame_tick     one-cycle pulse per video frame
//   run            ticks are counted only while high
//   clear          zero score/divider/saturated (new game), beats frame_tick
//   game_over      commit score to hi_score_bcd when it is larger
//   DrawX, DrawY   current pixel
//   score_bcd      current score, digit 0 (least significant) in [3:0]
//   hi_score_bcd   session high score
//   saturated      score has reached all nines (sticky until clear/reset)
//   is_score       pixel presented on the previous cycle is score foreground
//
//   digits_rom (below): 8x16 digit font, addr = 16*glyph + row, data[0] is
//   the leftmost pixel of the row.
// -----------------------------------------------------------------------------
module score_display #(
  parameter int         NUM_DIGITS  = 4,
  parameter int         UNIT_FRAMES = 30,
  parameter int         SCALE       = 3,
  parameter logic [9:0] X_POS       = 10'd540,
  parameter logic [9:0] Y_POS       = 10'd10,
  parameter int         DIGIT_PITCH = 8*SCALE+2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_tick,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    game_over,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hi_score_bcd,
  output logic                    saturated,
  output logic                    is_score
);

  localparam int SW = 4*NUM_DIGITS;
  localparam logic [11:0] DIV_LAST = 12'(UNIT_FRAMES-1);

  logic [SW-1:0] score_q, hi_q, score_next;
  logic [11:0]   div_q;
  logic          sat_q, pix_q;
  logic          count_en, wrap;

  // Ripple-carry BCD increment from digit 0 upward.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic all_nines(input logic [SW-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) r = r && (v[4*i +: 4] == 4'd9);
    return r;
  endfunction

  assign count_en   = frame_tick && run && !sat_q;
  assign wrap       = count_en && (div_q == DIV_LAST);
  assign score_next = bcd_inc(score_q);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= '0;
      div_q   <= '0;
      sat_q   <= 1'b0;
    end else if (clear) begin
      score_q <= '0;
      div_q   <= '0;
      sat_q   <= 1'b0;
    end else if (count_en) begin
      div_q <= wrap ? 12'd0 : div_q + 12'd1;
      if (wrap) begin
        score_q <= score_next;
        // Flag on the edge the score lands on all nines so the divider
        // stops from then on.
        if (all_nines(score_next)) sat_q <= 1'b1;
      end
    end
  end

  // Legal BCD with the MS digit in the top bits compares correctly as an
  // ordinary unsigned number. Uses the pre-clear score when clear coincides.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                         hi_q <= '0;
    else if (game_over && score_q > hi_q) hi_q <= score_q;
  end

  // ---------------------------------------------------------------- render
  logic [10:0] x11, y11, origin, dx, dy;
  logic [3:0]  digit, glyph, row;
  logic [2:0]  col;
  logic        hit, y_in, blank;
  logic [7:0]  rom_addr;
  logic [0:7]  rom_data;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
  logic        zeros_above;
`endif

  assign x11 = {1'b0, DrawX};
  assign y11 = {1'b0, DrawY};

  // Boxes never overlap, so at most one iteration can hit.
  always_comb begin
    hit    = 1'b0;
    dx     = '0;
    glyph  = '0;
    blank  = 1'b0;
    origin = '0;
    digit  = '0;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
    zeros_above = 1'b1;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      origin = 11'(X_POS) + 11'(k*DIGIT_PITCH);
      digit  = score_q[4*(NUM_DIGITS-1-k) +: 4];
      if (x11 >= origin && x11 < origin + 11'(8*SCALE)) begin
        hit   = 1'b1;
        dx    = x11 - origin;
        glyph = digit;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
        blank = zeros_above && (digit == 4'd0) && (k != NUM_DIGITS-1);
`endif
      end
`ifdef SCORE_LEAD_ZERO_BLANK_EN
      zeros_above = zeros_above && (digit == 4'd0);
`endif
    end
  end

  assign y_in     = (y11 >= 11'(Y_POS)) && (y11 < 11'(Y_POS) + 11'(16*SCALE));
  assign dy       = y11 - 11'(Y_POS);
  assign col      = 3'(dx / 11'(SCALE));
  assign row      = 4'(dy / 11'(SCALE));
  assign rom_addr = {glyph, row};

  digits_rom u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pix_q <= 1'b0;
    else          pix_q <= hit && y_in && !blank && rom_data[col];
  end

  assign score_bcd    = score_q;
  assign hi_score_bcd = hi_q;
  assign saturated    = sat_q;
  assign is_score     = pix_q;

endmodule

// 8x16 digit font drawn as seven-segment strokes: top bar row 1, middle bar
// row 7, bottom bar row 14, vertical strokes in columns 1 and 6. Glyphs above
// 9 are blank.
module digits_rom (
  input  logic [7:0] addr,
  output logic [0:7] data
);
  logic [3:0] glyph, row;
  logic [6:0] seg; // {a,b,c,d,e,f,g}

  assign glyph = addr[7:4];
  assign row   = addr[3:0];

  always_comb begin
    case (glyph)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
  end

  always_comb begin
    data = '0;
    if (row == 4'd1  && seg[6]) data[1:6] = 6'b111111;
    if (row == 4'd7  && seg[0]) data[1:6] = 6'b111111;
    if (row == 4'd14 && seg[3]) data[1:6] = 6'b111111;
    if (row >= 4'd1 && row <= 4'd7) begin
      if (seg[1]) data[1] = 1'b1;
      if (seg[5]) data[6] = 1'b1;
    end
    if (row >= 4'd7 && row <= 4'd14) begin
      if (seg[2]) data[1] = 1'b1;
      if (seg[4]) data[6] = 1'b1;
    end
  end
endmodule

// File: tb/tb_score_display.sv
// Bench for score_display. Instance 0 uses default parameters (counting,
// high score, rendering); instance 1 uses UNIT_FRAMES=3 so saturation at
// 9999 is reachable in a short run.
module tb_score_display;

  localparam int MAXS = 9999;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ft[2], rn[2], cl[2], go[2];
  logic [9:0]  draw_x, draw_y;
  logic [15:0] sc[2], hi[2];
  logic        sat[2], iss[2];

  score_display dut (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(ft[0]), .run(rn[0]),
    .clear(cl[0]), .game_over(go[0]), .DrawX(draw_x), .DrawY(draw_y),
    .score_bcd(sc[0]), .hi_score_bcd(hi[0]), .saturated(sat[0]),
    .is_score(iss[0])
  );

  score_display #(.UNIT_FRAMES(3)) dut_sat (
    .Clk(clk), .Reset_n(rst_n), .frame_tick(ft[1]), .run(rn[1]),
    .clear(cl[1]), .game_over(go[1]), .DrawX(draw_x), .DrawY(draw_y),
    .score_bcd(sc[1]), .hi_score_bcd(hi[1]), .saturated(sat[1]),
    .is_score(iss[1])
  );

  // ---------------------------------------------------- reference model
  int m_total[2];     // counted frame ticks since last clear
  int m_hi[2];        // high score as a plain integer
  int units[2] = '{30, 3};
  string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic int m_score(int i);
    return m_total[i] / units[i];
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r = '0;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_seg(int d, byte s);
    for (int i = 0; i < segs[d].len(); i++) if (segs[d][i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit font_px(int d, int row, int col);
    bit bar, v;
    bar = (col >= 1 && col <= 6);
    v = 1'b0;
    if (row == 1  && bar && has_seg(d, "a")) v = 1'b1;
    if (row == 7  && bar && has_seg(d, "g")) v = 1'b1;
    if (row == 14 && bar && has_seg(d, "d")) v = 1'b1;
    if (row >= 1 && row <= 7) begin
      if (col == 1 && has_seg(d, "f")) v = 1'b1;
      if (col == 6 && has_seg(d, "b")) v = 1'b1;
    end
    if (row >= 7 && row <= 14) begin
      if (col == 1 && has_seg(d, "e")) v = 1'b1;
      if (col == 6 && has_seg(d, "c")) v = 1'b1;
    end
    return v;
  endfunction

  // Expected foreground for the default-parameter instance showing `score`.
  function automatic bit model_pixel(int score, int x, int y);
    int origin, d, p10;
    bit lead;
    lead = 1'b1;
    p10  = 1000;
    for (int k = 0; k < 4; k++) begin
      d = (score / p10) % 10;
`ifdef SCORE_LEAD_ZERO_BLANK_EN
      lead = lead && (d == 0) && (k != 3);
`else
      lead = 1'b0;
`endif
      origin = 540 + k*26;
      if (x >= origin && x < origin + 24 && y >= 10 && y < 58)
        return !lead && font_px(d, (y - 10) / 3, (x - origin) / 3);
      p10 = p10 / 10;
    end
    return 1'b0;
  endfunction

  // ---------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input int i, input string tag);
    check({tag, "_score"}, 32'(sc[i]), 32'(to_bcd(m_score(i))));
    check({tag, "_hi"},    32'(hi[i]), 32'(to_bcd(m_hi[i])));
    check({tag, "_sat"},   32'(sat[i]), 32'(m_score(i) == MAXS));
  endtask

  // ---------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of control input on instance i; the model advances with it.
  task automatic apply(input int i, input bit t, input bit r, input bit c, input bit g);
    int s;
    ft[i] = t; rn[i] = r; cl[i] = c; go[i] = g;
    s = m_score(i);
    if (g && s > m_hi[i]) m_hi[i] = s;
    if (c) m_total[i] = 0;
    else if (t && r && m_total[i] < MAXS*units[i]) m_total[i]++;
    step();
    ft[i] = 1'b0; cl[i] = 1'b0; go[i] = 1'b0;
  endtask

  task automatic ticks(input int i, input int n, input bit r);
    repeat (n) apply(i, 1'b1, r, 1'b0, 1'b0);
  endtask

  task automatic count_to(input int i, input int target);
    apply(i, 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(i, target*units[i], 1'b1);
  endtask

  task automatic scan(input string tag);
    logic [0:0] e;
    for (int y = 8; y <= 60; y++) begin
      for (int x = 536; x <= 645; x++) begin
        draw_x = 10'(x);
        draw_y = 10'(y);
        exp_q.push_back(model_pixel(m_score(0), x, y));
        step();
        e = exp_q.pop_front();
        check(tag, 32'(iss[0]), 32'(e));
      end
    end
  endtask

  // ---------------------------------------------------- test sequence
  initial begin
    for (int i = 0; i < 2; i++) begin
      ft[i] = 0; rn[i] = 0; cl[i] = 0; go[i] = 0;
      m_total[i] = 0; m_hi[i] = 0;
    end
    draw_x = '0; draw_y = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_state(0, "rst");
    check("rst_is_score", 32'(iss[0]), 32'd0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset in the middle of a count, foreground pixel shown.
    count_to(0, 37);
    draw_x = 10'd627; draw_y = 10'd13;   // top bar of the '7'
    step();
    check("pre_rst_score", 32'(sc[0]), 32'h0037);
    check("pre_rst_pix", 32'(iss[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    m_total[0] = 0; m_hi[0] = 0; m_total[1] = 0; m_hi[1] = 0;
    check_state(0, "async_rst");
    check("async_rst_pix", 32'(iss[0]), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Divider boundaries and run gating.
    apply(0, 1'b0, 1'b1, 1'b1, 1'b0);
    ticks(0, 29, 1'b1);
    check("tick29", 32'(sc[0]), 32'h0000);
    ticks(0, 1, 1'b1);
    check("tick30", 32'(sc[0]), 32'h0001);
    ticks(0, 270, 1'b1);
    check("tick300", 32'(sc[0]), 32'h0010);
    ticks(0, 50, 1'b0);
    check("run_low", 32'(sc[0]), 32'h0010);
    ticks(0, 29, 1'b1);
    check("div_held29", 32'(sc[0]), 32'h0010);
    ticks(0, 1, 1'b1);
    check("div_held30", 32'(sc[0]), 32'h0011);
    check_state(0, "run");

    // Double carry.
    count_to(0, 199);
    check("s199", 32'(sc[0]), 32'h0199);
    ticks(0, 30, 1'b1);
    check("s200", 32'(sc[0]), 32'h0200);

    // High score commit and hold.
    count_to(0, 123);
    apply(0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("hi123", 32'(hi[0]), 32'h0123);
    count_to(0, 50);
    apply(0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("hi_hold", 32'(hi[0]), 32'h0123);
    check_state(0, "hi");

    // clear beats a coincident frame_tick and zeroes the divider.
    ticks(0, 5, 1'b1);
    apply(0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_tick", 32'(sc[0]), 32'h0000);
    ticks(0, 29, 1'b1);
    check("clr_div29", 32'(sc[0]), 32'h0000);
    ticks(0, 1, 1'b1);
    check("clr_div30", 32'(sc[0]), 32'h0001);

    // Rendering.
    count_to(0, 42);
    scan("pix42");
    count_to(0, 123);
    scan("pix123");

    // Randomised control traffic against the model.
    for (int n = 0; n < 600; n++) begin
      apply(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 60) == 0), ($urandom_range(0, 40) == 0));
      check_state(0, "rand");
    end

    // game_over and clear together use the pre-clear score.
    count_to(1, 300);
    apply(1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("hi300", 32'(hi[1]), 32'h0300);
    count_to(1, 500);
    apply(1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("go_clr_hi", 32'(hi[1]), 32'h0500);
    check("go_clr_score", 32'(sc[1]), 32'h0000);

    // Saturation.
    count_to(1, MAXS - 1);
    check("pre_sat", 32'(sat[1]), 32'd0);
    ticks(1, 3, 1'b1);
    check("sat_score", 32'(sc[1]), 32'h9999);
    check("sat_flag", 32'(sat[1]), 32'd1);
    ticks(1, 90, 1'b1);
    check("sat_hold", 32'(sc[1]), 32'h9999);
    check_state(1, "sat");
    apply(1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sat_hi", 32'(hi[1]), 32'h9999);
    apply(1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_clr", 32'(sat[1]), 32'd0);
    check_state(1, "final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Parameterised real-time score keeper and renderer for the StickmanRun VGA overlay.
- Counts survived distance in BCD from a per-frame tick, saturates, and keeps a session high score.
- Draws NUM_DIGITS scaled glyphs from the existing digits_rom font and tells the color mapper whether the current pixel is score foreground.
- Replaces the fixed two-digit combinational scorer. All state is clocked.

Parameters:
- NUM_DIGITS, 4: decimal digits kept and drawn (1..6).
- UNIT_FRAMES, 30: frame ticks per score point (1..4095).
- SCALE, 3: integer pixel magnification of the 8x16 glyph (1..4).
- X_POS, 10'd540: left pixel column of the most-significant digit.
- Y_POS, 10'd10: top pixel row of the digits.
- DIGIT_PITCH, 8*SCALE+2: horizontal pixel distance between digit origins.

Ports:
- Clk  input  1  50 MHz system clock.
- Reset_n  input  1  asynchronous active-low reset.
- frame_tick  input  1  one-cycle pulse, once per video frame.
- run  input  1  game running; ticks are counted only while high.
- clear  input  1  one-cycle pulse that zeroes the current score (new game).
- game_over  input  1  one-cycle pulse that commits the current score to the high score.
- DrawX  input  10  current pixel column.
- DrawY  input  10  current pixel row.
- score_bcd  output  4*NUM_DIGITS  current score in BCD; digit 0 is in bits [3:0].
- hi_score_bcd  output  4*NUM_DIGITS  session high score in BCD.
- saturated  output  1  score has reached all nines.
- is_score  output  1  pixel (DrawX,DrawY) sampled the previous cycle is score foreground.

Behaviour:
- Reset (Reset_n low, asynchronous): score_bcd=0, hi_score_bcd=0, saturated=0, is_score=0, divider=0. Release is synchronous to Clk.
- Divider:
  - Counts 0..UNIT_FRAMES-1 on each cycle with frame_tick && run && !saturated.
  - When it wraps from UNIT_FRAMES-1 to 0, the score increments on that same edge.
  - With run low, the divider and score hold.
- BCD increment:
  - Ripple carry from digit 0 upward. A digit at 9 becomes 0 and carries; other digits add 1.
  - Each digit is always a legal value 0..9.
- Saturation:
  - When the score is all nines (e.g. 9999 for 4 digits), further increments are suppressed and saturated=1.
  - saturated is sticky until clear or reset.
- clear:
  - Sets score=0, divider=0, saturated=0 on the next edge.
  - clear has priority over a coincident frame_tick (no increment that cycle).
  - hi_score_bcd is unaffected.
- game_over:
  - If score_bcd > hi_score_bcd (unsigned BCD compare, most-significant digit first), hi_score_bcd <= score_bcd on the next edge. Otherwise it holds.
  - If game_over and clear arrive in the same cycle, the compare uses the pre-clear score, then the score clears.
- Render (combinational front end, registered output, latency exactly 1 cycle):
  - Digit k (k=0 is most significant) occupies the box X_POS+k*DIGIT_PITCH <= DrawX < that origin + 8*SCALE, and Y_POS <= DrawY < Y_POS+16*SCALE.
  - Within the box: col=(DrawX-origin)/SCALE and row=(DrawY-Y_POS)/SCALE, computed with constant division.
  - ROM address = 16*glyph+row, where glyph is that digit's BCD value. Font bit index col uses MSB-left ordering (bit 0 of a [0:7] row is the leftmost pixel).
  - is_score <= in_box && font_bit.
  - Gap pixels between boxes, and all pixels outside every box, give 0.
  - Box bounds use 11-bit arithmetic so X_POS+width cannot wrap.
- Exactly one digits_rom lookup per cycle. Boxes never overlap because DIGIT_PITCH >= 8*SCALE; parameter values that break this are illegal.

Optional Feature:
- Macro: SCORE_LEAD_ZERO_BLANK_EN.
- Defined: leading zero digits are blanked (is_score=0 across their boxes). The least-significant digit is always drawn, so a score of 0 shows a single "0" and 42 shows as "  42".
- Undefined: all NUM_DIGITS digits are drawn, including leading zeros ("0042").
- Counting, saturation and the high score are identical in both builds.

Test Plan:
- Reset mid-count (score=0x0037), assert Reset_n=0 asynchronously -> score_bcd=0, hi_score_bcd=0, saturated=0, is_score=0 before the next Clk edge.
- run=1, UNIT_FRAMES=30, 300 frame_ticks -> score_bcd=0x0010; tick 29 leaves 0x0000, tick 30 gives 0x0001; run=0 for 50 ticks -> no change.
- Preload by counting to 0x0199, then 30 more ticks -> 0x0200 (double carry). Count to 0x9999 -> saturated=1; 90 more ticks -> still 0x9999.
- Score 0x0123, game_over -> hi=0x0123. clear, count to 0x0050, game_over -> hi stays 0x0123. clear and frame_tick in the same cycle -> score 0, divider 0.
- Score 0x0042, scan the frame with SCALE=3 -> is_score one cycle after DrawX/DrawY. Foreground matches the font rows of '0','0','4','2' (macro off) or blank,blank,'4','2' (macro on). Pixels at X_POS-1 and in the gaps are 0.
- game_over with clear in the same cycle, score 0x0500 > hi 0x0300 -> hi=0x0500 and score=0.
